// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with write-first bypass, shift mode and bulk clear.
// Optional per-entry even parity when REGFILE_PARITY_EN is defined.
module regfile_mp #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     en,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     shift_en,
    input  logic                     clr_req,
`ifdef REGFILE_PARITY_EN
    input  logic                     par_inj,
    output logic [NUM_RD-1:0]        rd_perr,
`endif
    output logic                     clr_busy,
    output logic                     clr_done,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data
);

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_e;

    state_e                    state_q;
    logic [AW-1:0]             cnt_q;
    logic                      done_q;
    logic [DATA_W-1:0]         mem_q [DEPTH];
    logic [DATA_W-1:0]         mem_d [DEPTH];
    logic [NUM_RD*DATA_W-1:0]  rd_q;
    logic [NUM_RD*DATA_W-1:0]  rd_d;
    logic [AW-1:0]             ra [NUM_RD];
    logic                      busy;
    logic                      wr_ok;
    logic                      do_shift;
    logic                      do_wr;

    function automatic logic in_rng(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_W);
    endfunction

    for (genvar p = 0; p < NUM_RD; p++) begin : g_ra
        assign ra[p] = rd_addr[p*AW +: AW];
    end

    assign busy     = (state_q == S_CLEAR);
    assign wr_ok    = in_rng(wr_addr);
    assign do_shift = !busy && shift_en;
    assign do_wr    = !busy && !shift_en && wr_en && wr_ok;

    assign clr_busy = busy;
    assign clr_done = done_q;
    assign rd_data  = rd_q;

    // Array next state: clear engine beats shift, shift beats write.
    always_comb begin
        mem_d = mem_q;
        unique case (1'b1)
            busy: begin
                mem_d[cnt_q] = '0;
            end
            do_shift: begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem_d[i] = mem_q[i+1];
                end
                mem_d[DEPTH-1] = wr_data;
            end
            do_wr: begin
                mem_d[wr_addr] = wr_data;
            end
            default: ;
        endcase
    end

    // Read-first against the array, write-first only for a plain write.
    always_comb begin
        rd_d = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (do_wr && (ra[p] == wr_addr)) begin
                rd_d[p*DATA_W +: DATA_W] = wr_data;
            end else if (in_rng(ra[p])) begin
                rd_d[p*DATA_W +: DATA_W] = mem_q[ra[p]];
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mem_q   <= '{default: '0};
            rd_q    <= '0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else if (!en) begin
            done_q  <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            rd_q    <= rd_d;
            done_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (clr_req) begin
                        state_q <= S_CLEAR;
                        cnt_q   <= '0;
                    end
                end
                S_CLEAR: begin
                    cnt_q <= cnt_q + AW'(1);
                    if (cnt_q == LAST) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef REGFILE_PARITY_EN
    logic              par_q [DEPTH];
    logic              par_d [DEPTH];
    logic [NUM_RD-1:0] perr_q;
    logic [NUM_RD-1:0] perr_d;

    assign rd_perr = perr_q;

    always_comb begin
        par_d = par_q;
        unique case (1'b1)
            busy: begin
                par_d[cnt_q] = 1'b0;
            end
            do_shift: begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    par_d[i] = par_q[i+1];
                end
                par_d[DEPTH-1] = ^wr_data;
            end
            do_wr: begin
                par_d[wr_addr] = (^wr_data) ^ par_inj;
            end
            default: ;
        endcase
    end

    always_comb begin
        perr_d = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (!(do_wr && (ra[p] == wr_addr)) && in_rng(ra[p])) begin
                perr_d[p] = (^mem_q[ra[p]]) ^ par_q[ra[p]];
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            par_q  <= '{default: 1'b0};
            perr_q <= '0;
        end else if (en) begin
            par_q  <= par_d;
            perr_q <= perr_d;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed + random checks of regfile_mp against an array-level reference model.
module tb_regfile_mp;

    localparam int DW = 8;
    localparam int D  = 32;
    localparam int NR = 4;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          en = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          shift_en = 1'b0;
    logic          clr_req = 1'b0;
    logic          clr_busy;
    logic          clr_done;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR*DW-1:0] rd_data;
`ifdef REGFILE_PARITY_EN
    logic          par_inj = 1'b0;
    logic [NR-1:0] rd_perr;
`endif

    regfile_mp #(.DATA_W(DW), .DEPTH(D), .NUM_RD(NR)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .en       (en),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .shift_en (shift_en),
        .clr_req  (clr_req),
`ifdef REGFILE_PARITY_EN
        .par_inj  (par_inj),
        .rd_perr  (rd_perr),
`endif
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain array plus "clears remaining" count.
    int               mem [D];
    logic [NR*DW-1:0] exp_rd;
    int               clr_left;
    bit               exp_done;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        foreach (mem[i]) mem[i] = 0;
        exp_rd   = '0;
        clr_left = 0;
        exp_done = 0;
    endtask

    task automatic model_step(input bit e, input bit we, input int wa,
                              input int wd, input bit sh, input bit cr,
                              input logic [NR*AW-1:0] ra);
        bit busy;
        int a;
        int v;
        exp_done = 0;
        if (!e) return;
        busy = (clr_left > 0);
        for (int p = 0; p < NR; p++) begin
            a = int'(ra[p*AW +: AW]);
            v = mem[a];
            if (!busy && we && !sh && a == wa) v = wd;
            exp_rd[p*DW +: DW] = DW'(v);
        end
        if (busy) begin
            mem[D - clr_left] = 0;
            clr_left--;
            if (clr_left == 0) exp_done = 1;
        end else begin
            if (sh) begin
                for (int i = 0; i < D - 1; i++) mem[i] = mem[i+1];
                mem[D-1] = wd;
            end else if (we) begin
                mem[wa] = wd;
            end
            if (cr) clr_left = D;
        end
    endtask

    task automatic cyc(input bit e, input bit we, input int wa, input int wd,
                       input bit sh, input bit cr, input logic [NR*AW-1:0] ra);
        @(negedge clk);
        en       = e;
        wr_en    = we;
        wr_addr  = AW'(wa);
        wr_data  = DW'(wd);
        shift_en = sh;
        clr_req  = cr;
        rd_addr  = ra;
        model_step(e, we, wa, wd, sh, cr, ra);
        @(posedge clk);
        #1;
        chk("rd_data", 64'(rd_data), 64'(exp_rd));
        chk("clr_busy", 64'(clr_busy), 64'(clr_left > 0));
        chk("clr_done", 64'(clr_done), 64'(exp_done));
    endtask

    task automatic do_reset();
        @(negedge clk);
        en = 0; wr_en = 0; shift_en = 0; clr_req = 0;
        #7;
        nrst = 0;
        model_reset();
        #1;
        chk("rst_rd", 64'(rd_data), 64'd0);
        chk("rst_busy", 64'(clr_busy), 64'd0);
        chk("rst_done", 64'(clr_done), 64'd0);
        @(negedge clk);
        nrst = 1;
    endtask

    function automatic logic [NR*AW-1:0] pk(input int a0, input int a1,
                                             input int a2, input int a3);
        return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endfunction

    task automatic read_all_zero(input string tag);
        for (int k = 0; k < D / 4; k++) begin
            cyc(1, 0, 0, 0, 0, 0, pk(4*k, 4*k+1, 4*k+2, 4*k+3));
            chk(tag, 64'(rd_data), 64'd0);
        end
    endtask

    int nb;
    int nd;

    initial begin
        model_reset();
        #3;
        chk("init_rd", 64'(rd_data), 64'd0);
        chk("init_busy", 64'(clr_busy), 64'd0);
        chk("init_done", 64'(clr_done), 64'd0);
        @(negedge clk);
        nrst = 1;

        // preload, reset mid-cycle, everything reads back zero
        for (int i = 0; i < 8; i++) cyc(1, 1, i * 4 + 1, 8'h30 + i, 0, 0, '0);
        do_reset();
        read_all_zero("rst_entry");

        // write / read
        cyc(1, 1, 7, 8'hA5, 0, 0, '0);
        cyc(1, 1, 31, 8'h3C, 0, 0, '0);
        cyc(1, 0, 0, 0, 0, 0, pk(7, 31, 7, 0));
        chk("wr_rd", 64'(rd_data), 64'h00A5_3CA5);

        // bypass
        cyc(1, 1, 5, 8'h77, 0, 0, '0);
        cyc(1, 0, 0, 0, 0, 0, pk(0, 5, 0, 0));
        chk("byp_old", 64'(rd_data[15:8]), 64'h77);
        cyc(1, 1, 5, 8'h11, 0, 0, pk(0, 5, 5, 0));
        chk("byp_p2", 64'(rd_data[23:16]), 64'h11);
        chk("byp_p1", 64'(rd_data[15:8]), 64'h11);

        // en low: state and outputs frozen, request not captured
        cyc(1, 1, 2, 8'h99, 0, 0, pk(2, 2, 2, 2));
        cyc(0, 1, 2, 8'h44, 1, 1, pk(9, 9, 9, 9));
        chk("en0_hold", 64'(rd_data), 64'h9999_9999);
        chk("en0_noclr", 64'(clr_busy), 64'd0);
        cyc(1, 0, 0, 0, 0, 0, pk(2, 0, 0, 0));
        chk("en0_nowr", 64'(rd_data[7:0]), 64'h99);

`ifdef REGFILE_PARITY_EN
        par_inj = 1;
        cyc(1, 1, 3, 8'h0F, 0, 0, pk(3, 0, 0, 0));
        chk("perr_byp", 64'(rd_perr[0]), 64'd0);
        par_inj = 0;
        cyc(1, 0, 0, 0, 0, 0, pk(3, 3, 3, 3));
        chk("perr_inj", 64'(rd_perr), 64'hF);
        cyc(1, 1, 3, 8'h0F, 0, 0, '0);
        cyc(1, 0, 0, 0, 0, 0, pk(3, 3, 3, 3));
        chk("perr_clr", 64'(rd_perr), 64'h0);
`endif

        // shift
        for (int i = 0; i < D; i++) cyc(1, 1, i, i, 0, 0, '0);
        cyc(1, 1, 0, 8'hFF, 1, 0, pk(0, 31, 0, 0));
        chk("sh_rdfirst", 64'(rd_data[15:0]), 64'h1F00);
        cyc(1, 0, 0, 0, 0, 0, pk(0, 30, 31, 1));
        chk("sh_result", 64'(rd_data), 64'h02FF_1F01);

        // clear with mid-clear request, write and shift
        for (int i = 0; i < D; i++) cyc(1, 1, i, 8'h55, 0, 0, '0);
        cyc(1, 0, 0, 0, 0, 1, '0);
        nb = int'(clr_busy);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1, i == 9, 3, 8'hAA, i == 12, i == 5, NR*AW'($urandom));
            nb += int'(clr_busy);
            nd += int'(clr_done);
        end
        chk("clr_len", 64'(nb), 64'(D));
        chk("clr_pulses", 64'(nd), 64'd1);
        read_all_zero("clr_entry");

        // reset mid-clear aborts with no done pulse
        cyc(1, 0, 0, 0, 0, 1, '0);
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0, 0, '0);
        do_reset();
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1, 0, 0, 0, 0, 0, '0);
            nd += int'(clr_done);
        end
        chk("rst_noclr", 64'(nd), 64'd0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 9) != 0,
                $urandom_range(0, 1) == 1,
                int'($urandom_range(0, D - 1)),
                int'($urandom_range(0, 255)),
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 39) == 0,
                NR*AW'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
